// File: rtl/io_dec_pkg.sv
// rtl/io_dec_pkg.sv - shared constants, reset values and FSM states for the I/O address decoder
//
// Contents:
//   REG_*        register offsets inside one window's 8-entry config block
//   OP_*         bit positions of the op register (direction gating)
//   *_RST        config reset values
//   state_t      cycle FSM states
//   op_permits   direction gating helper used by every window matcher

package io_dec_pkg;

    localparam logic [2:0] REG_BASE_LO = 3'd0;
    localparam logic [2:0] REG_BASE_HI = 3'd1;
    localparam logic [2:0] REG_MASK_LO = 3'd2;
    localparam logic [2:0] REG_MASK_HI = 3'd3;
    localparam logic [2:0] REG_SLOT    = 3'd4;
    localparam logic [2:0] REG_OP      = 3'd5;
    localparam logic [2:0] REG_WAIT    = 3'd6;
    localparam logic [2:0] REG_RSVD    = 3'd7;

    localparam int OP_RD_ONLY = 0;
    localparam int OP_WR_ONLY = 1;

    // Both op bits set means the window matches nothing, so windows come out of reset disabled.
    localparam logic [1:0] OP_RST   = 2'b11;
    localparam logic [3:0] WAIT_RST = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } state_t;

    // A read-only window rejects writes, a write-only window rejects reads.
    function automatic logic op_permits(input logic [1:0] op, input logic r_w_);
        return r_w_ ? !op[OP_WR_ONLY] : !op[OP_RD_ONLY];
    endfunction

endpackage

// File: rtl/io_win_match.sv
// rtl/io_win_match.sv - one decode window: masked base compare plus direction gating
//
// Ports:
//   addr   in   CPU I/O address
//   r_w_   in   1 = read, 0 = write
//   base   in   window base address
//   mask   in   compare mask (1 = bit participates)
//   slot   in   chip-select slot owned by this window
//   op     in   direction gating bits
//   hit    out  window claims this cycle

module io_win_match
    import io_dec_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int NUM_SLOTS = 5,
    parameter int SLOT_W    = 3
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              r_w_,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] mask,
    input  logic [SLOT_W-1:0] slot,
    input  logic [1:0]        op,
    output logic              hit
);

    // A window pointing at a slot that does not exist never claims a cycle.
    assign hit = (((addr ^ base) & mask) == '0)
               && op_permits(op, r_w_)
               && (int'(slot) < NUM_SLOTS);

endmodule

// File: rtl/io_addr_decoder_v2.sv
// rtl/io_addr_decoder_v2.sv - programmable I/O window decoder with wait states, timeout and config readback
//
// Ports:
//   clk, rst_n                       system clock, asynchronous active-low reset
//   addr, iorq_n, r_w_               CPU I/O cycle
//   dev_ready_n                      per-slot device ready (1 = ready)
//   irq_vec_cycle, irq_int_active,
//   irq_int_slot                     interrupt-vector fetch override
//   cfg_we, cfg_addr, cfg_wdata      config write port {window, reg}
//   cfg_rdata                        combinational config readback
//   cs_n, ready_n, io_r_w_,
//   data_oe_n, data_dir              cycle outputs
//   win_valid, win_index, sel_slot   latched decode result
//   bus_err, err_addr                timeout pulse and address of the last timed-out cycle

module io_addr_decoder_v2
    import io_dec_pkg::*;
#(
    parameter  int ADDR_W      = 16,
    parameter  int NUM_WIN     = 8,
    parameter  int NUM_SLOTS   = 5,
    parameter  int TIMEOUT_CYC = 64,
    localparam int SLOT_W      = $clog2(NUM_SLOTS),
    localparam int WIN_W       = $clog2(NUM_WIN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 iorq_n,
    input  logic                 r_w_,
    input  logic [NUM_SLOTS-1:0] dev_ready_n,
    input  logic                 irq_vec_cycle,
    input  logic                 irq_int_active,
    input  logic [SLOT_W-1:0]    irq_int_slot,
    input  logic                 cfg_we,
    input  logic [WIN_W+2:0]     cfg_addr,
    input  logic [7:0]           cfg_wdata,
    output logic [7:0]           cfg_rdata,
    output logic [NUM_SLOTS-1:0] cs_n,
    output logic                 ready_n,
    output logic                 io_r_w_,
    output logic                 data_oe_n,
    output logic                 data_dir,
    output logic                 win_valid,
    output logic [WIN_W-1:0]     win_index,
    output logic [SLOT_W-1:0]    sel_slot,
    output logic                 bus_err,
    output logic [ADDR_W-1:0]    err_addr
);

    localparam int TC_W = $clog2(TIMEOUT_CYC) + 1;

    // ---------------------------------------------------------------
    // Config register file
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] base_q [NUM_WIN];
    logic [ADDR_W-1:0] mask_q [NUM_WIN];
    logic [SLOT_W-1:0] slot_q [NUM_WIN];
    logic [1:0]        op_q   [NUM_WIN];
    logic [3:0]        wait_q [NUM_WIN];

    logic [WIN_W-1:0] cfg_win;
    logic [2:0]       cfg_reg;

    assign cfg_win = cfg_addr[WIN_W+2:3];
    assign cfg_reg = cfg_addr[2:0];

    // Registers are exposed as 16-bit byte pairs; bits at or above ADDR_W are dropped.
    function automatic logic [ADDR_W-1:0] put_byte(input logic [ADDR_W-1:0] cur,
                                                   input logic             hi,
                                                   input logic [7:0]       b);
        logic [15:0] w;
        w = 16'(cur);
        if (hi) w[15:8] = b;
        else    w[7:0]  = b;
        return w[ADDR_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                base_q[i] <= '0;
                mask_q[i] <= '0;
                slot_q[i] <= '0;
                op_q[i]   <= OP_RST;
                wait_q[i] <= WAIT_RST;
            end
        end else if (cfg_we) begin
            case (cfg_reg)
                REG_BASE_LO: base_q[cfg_win] <= put_byte(base_q[cfg_win], 1'b0, cfg_wdata);
                REG_BASE_HI: base_q[cfg_win] <= put_byte(base_q[cfg_win], 1'b1, cfg_wdata);
                REG_MASK_LO: mask_q[cfg_win] <= put_byte(mask_q[cfg_win], 1'b0, cfg_wdata);
                REG_MASK_HI: mask_q[cfg_win] <= put_byte(mask_q[cfg_win], 1'b1, cfg_wdata);
                REG_SLOT:    slot_q[cfg_win] <= cfg_wdata[SLOT_W-1:0];
                REG_OP:      op_q[cfg_win]   <= cfg_wdata[1:0];
                REG_WAIT:    wait_q[cfg_win] <= cfg_wdata[3:0];
                default:     ;
            endcase
        end
    end

    logic [15:0] rd_base16;
    logic [15:0] rd_mask16;

    always_comb begin
        cfg_rdata = '0;
        rd_base16 = 16'(base_q[cfg_win]);
        rd_mask16 = 16'(mask_q[cfg_win]);
        case (cfg_reg)
            REG_BASE_LO: cfg_rdata = rd_base16[7:0];
            REG_BASE_HI: cfg_rdata = rd_base16[15:8];
            REG_MASK_LO: cfg_rdata = rd_mask16[7:0];
            REG_MASK_HI: cfg_rdata = rd_mask16[15:8];
            REG_SLOT:    cfg_rdata[SLOT_W-1:0] = slot_q[cfg_win];
            REG_OP:      cfg_rdata[1:0] = op_q[cfg_win];
            REG_WAIT:    cfg_rdata[3:0] = wait_q[cfg_win];
            REG_RSVD:    cfg_rdata = '0;
            default:     cfg_rdata = '0;
        endcase
    end

    // ---------------------------------------------------------------
    // Window matchers and priority encoder
    // ---------------------------------------------------------------
    logic [NUM_WIN-1:0] win_hit;

    for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
        io_win_match #(
            .ADDR_W    (ADDR_W),
            .NUM_SLOTS (NUM_SLOTS),
            .SLOT_W    (SLOT_W)
        ) u_match (
            .addr (addr),
            .r_w_ (r_w_),
            .base (base_q[g]),
            .mask (mask_q[g]),
            .slot (slot_q[g]),
            .op   (op_q[g]),
            .hit  (win_hit[g])
        );
    end

    logic             pe_hit;
    logic [WIN_W-1:0] pe_idx;

    // Scan from the top so the lowest hitting index is the last one written.
    always_comb begin
        pe_hit = 1'b0;
        pe_idx = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                pe_hit = 1'b1;
                pe_idx = WIN_W'(i);
            end
        end
    end

    // ---------------------------------------------------------------
    // Decode result presented to the FSM at cycle entry
    // ---------------------------------------------------------------
    logic                 irq_ovr;
    logic [SLOT_W-1:0]    dec_sel;
    logic                 dec_ok;
    logic [3:0]           dec_wait;
    logic [NUM_SLOTS-1:0] dec_cs_n;

    always_comb begin
        irq_ovr  = irq_vec_cycle && irq_int_active;
        dec_sel  = '0;
        dec_ok   = 1'b0;
        dec_wait = '0;
        if (irq_ovr) begin
            dec_sel = irq_int_slot;
            dec_ok  = int'(irq_int_slot) < NUM_SLOTS;
        end else if (pe_hit) begin
            dec_sel  = slot_q[pe_idx];
            dec_ok   = 1'b1;
            dec_wait = wait_q[pe_idx];
        end
        for (int i = 0; i < NUM_SLOTS; i++) begin
            dec_cs_n[i] = !(dec_ok && (dec_sel == SLOT_W'(i)));
        end
    end

    // Pad ready to a power of two so indexing by the latched slot is always in range.
    logic [(1 << SLOT_W)-1:0] dev_rdy_ext;

    always_comb begin
        dev_rdy_ext = '0;
        dev_rdy_ext[NUM_SLOTS-1:0] = dev_ready_n;
    end

    // ---------------------------------------------------------------
    // Cycle FSM
    // ---------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [3:0]           wcnt_q,      wcnt_d;
    logic [TC_W-1:0]      tcnt_q,      tcnt_d;
    logic [ADDR_W-1:0]    lat_addr_q,  lat_addr_d;
    logic [SLOT_W-1:0]    cyc_sel_q,   cyc_sel_d;
    logic                 cyc_ok_q,    cyc_ok_d;
    logic [NUM_SLOTS-1:0] cs_n_d;
    logic                 ready_n_d, io_r_w_d, data_oe_n_d, data_dir_d;
    logic                 win_valid_d, bus_err_d;
    logic [WIN_W-1:0]     win_index_d;
    logic [SLOT_W-1:0]    sel_slot_d;
    logic [ADDR_W-1:0]    err_addr_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wcnt_q     <= '0;
            tcnt_q     <= '0;
            lat_addr_q <= '0;
            cyc_sel_q  <= '0;
            cyc_ok_q   <= 1'b0;
            cs_n       <= '1;
            ready_n    <= 1'b1;
            io_r_w_    <= 1'b1;
            data_oe_n  <= 1'b1;
            data_dir   <= 1'b1;
            win_valid  <= 1'b0;
            win_index  <= '0;
            sel_slot   <= '0;
            bus_err    <= 1'b0;
            err_addr   <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            tcnt_q     <= tcnt_d;
            lat_addr_q <= lat_addr_d;
            cyc_sel_q  <= cyc_sel_d;
            cyc_ok_q   <= cyc_ok_d;
            cs_n       <= cs_n_d;
            ready_n    <= ready_n_d;
            io_r_w_    <= io_r_w_d;
            data_oe_n  <= data_oe_n_d;
            data_dir   <= data_dir_d;
            win_valid  <= win_valid_d;
            win_index  <= win_index_d;
            sel_slot   <= sel_slot_d;
            bus_err    <= bus_err_d;
            err_addr   <= err_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        tcnt_d      = tcnt_q;
        lat_addr_d  = lat_addr_q;
        cyc_sel_d   = cyc_sel_q;
        cyc_ok_d    = cyc_ok_q;
        cs_n_d      = cs_n;
        ready_n_d   = ready_n;
        io_r_w_d    = io_r_w_;
        data_oe_n_d = data_oe_n;
        data_dir_d  = data_dir;
        win_valid_d = win_valid;
        win_index_d = win_index;
        sel_slot_d  = sel_slot;
        bus_err_d   = 1'b0;
        err_addr_d  = err_addr;

        case (state_q)
            IDLE: begin
                if (!iorq_n) begin
                    state_d     = ACTIVE;
                    lat_addr_d  = addr;
                    cyc_sel_d   = dec_sel;
                    cyc_ok_d    = dec_ok;
                    wcnt_d      = dec_wait;
                    tcnt_d      = '0;
                    cs_n_d      = dec_cs_n;
                    ready_n_d   = 1'b0;
                    io_r_w_d    = r_w_;
                    data_dir_d  = r_w_;
                    data_oe_n_d = !dec_ok;
                    win_valid_d = !irq_ovr && pe_hit;
                    win_index_d = irq_ovr ? '0 : pe_idx;
                    sel_slot_d  = dec_sel;
                end
            end

            ACTIVE: begin
                if (iorq_n) begin
                    state_d     = IDLE;
                    cs_n_d      = '1;
                    ready_n_d   = 1'b1;
                    io_r_w_d    = 1'b1;
                    data_oe_n_d = 1'b1;
                    data_dir_d  = 1'b1;
                end else begin
                    if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
                    // The last wait state and the first ready sample can share an edge,
                    // so wait = N releases ready_n N edges after entry (min one).
                    if (wcnt_q <= 4'd1) begin
                        if (!cyc_ok_q || dev_rdy_ext[cyc_sel_q]) begin
                            ready_n_d = 1'b1;
                            state_d   = DONE;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                            if (tcnt_d == TC_W'(TIMEOUT_CYC - 1)) begin
                                ready_n_d  = 1'b1;
                                bus_err_d  = 1'b1;
                                err_addr_d = lat_addr_q;
                                state_d    = DONE;
                            end
                        end
                    end
                end
            end

            DONE: begin
                if (iorq_n) begin
                    state_d     = IDLE;
                    cs_n_d      = '1;
                    ready_n_d   = 1'b1;
                    io_r_w_d    = 1'b1;
                    data_oe_n_d = 1'b1;
                    data_dir_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule
